// File: rtl/p_addsub_arb.sv
// p_addsub_arb: two-requester round-robin (or fixed-priority) front end for a
// shared packed add/subtract datapath, with a single-entry response buffer.
// A request is accepted when the buffer is empty or is being popped in the
// same cycle; the result is returned one cycle later on the winner's port.

// p_addsub: lane-wise packed add/subtract. Carries never cross a lane boundary;
// subtraction is lhs + ~rhs + 1 with the +1 injected at every lane start.
module p_addsub (
  input  logic [31:0] lhs_i,
  input  logic [31:0] rhs_i,
  input  logic [4:0]  pw_i,
  input  logic        sub_i,
  output logic [31:0] result_o
);

  // Ripple adder whose carry chain is restarted at each lane boundary.
  always_comb begin : lane_adder
    logic carry;
    logic rhs_bit;
    logic lane_start;
    logic cin;
    result_o   = '0;
    carry      = 1'b0;
    rhs_bit    = 1'b0;
    lane_start = 1'b0;
    cin        = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rhs_bit    = rhs_i[i] ^ sub_i;
      lane_start = (i == 0) ||
                   (pw_i[1] && ((i % 16) == 0)) ||
                   (pw_i[2] && ((i % 8) == 0))  ||
                   (pw_i[3] && ((i % 4) == 0))  ||
                   (pw_i[4] && ((i % 2) == 0));
      cin         = lane_start ? sub_i : carry;
      result_o[i] = lhs_i[i] ^ rhs_bit ^ cin;
      carry       = (lhs_i[i] & rhs_bit) | (cin & (lhs_i[i] ^ rhs_bit));
    end
  end

endmodule

module p_addsub_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_lhs,
  input  logic [31:0] req0_rhs,
  input  logic [4:0]  req0_pw,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_lhs,
  input  logic [31:0] req1_rhs,
  input  logic [4:0]  req1_pw,
  input  logic        req1_sub,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_err
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic        own_q, own_d;
  logic        last_q, last_d;

  logic        full;
  logic        pop;
  logic        can_accept;
  logic        gnt;
  logic        any_valid;
  logic        accept;

  logic [31:0] mux_lhs;
  logic [31:0] mux_rhs;
  logic [4:0]  mux_pw;
  logic        mux_sub;
  logic        pw_illegal;
  logic [31:0] alu_result;

  assign full = (state_q == ST_FULL);

  // Grant selection, pop detection and accept qualification.
  always_comb begin
    pop        = full & (own_q ? rsp1_ready : rsp0_ready);
    can_accept = ~full | pop;
    any_valid  = req0_valid | req1_valid;
    if (req0_valid && !req1_valid) begin
      gnt = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      gnt = 1'b1;
    end else if (req0_valid && req1_valid) begin
      gnt = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      gnt = 1'b0;
    end
    // Readies are forced low while reset is held, since the buffer is
    // empty then and would otherwise advertise space.
    accept     = any_valid & can_accept & g_resetn;
    req0_ready = accept & (gnt == 1'b0);
    req1_ready = accept & (gnt == 1'b1);
  end

  // Winner's operands feed the one shared datapath.
  always_comb begin
    mux_lhs    = gnt ? req1_lhs : req0_lhs;
    mux_rhs    = gnt ? req1_rhs : req0_rhs;
    mux_pw     = gnt ? req1_pw  : req0_pw;
    mux_sub    = gnt ? req1_sub : req0_sub;
    pw_illegal = (mux_pw == 5'd0) || ((mux_pw & (mux_pw - 5'd1)) != 5'd0);
  end

  p_addsub u_addsub (
    .lhs_i    (mux_lhs),
    .rhs_i    (mux_rhs),
    .pw_i     (mux_pw),
    .sub_i    (mux_sub),
    .result_o (alu_result)
  );

  // Buffer next-state and capture of the accepted result.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    err_d   = err_q;
    own_d   = own_q;
    last_d  = last_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (pop && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      res_d  = pw_illegal ? 32'd0 : alu_result;
      err_d  = pw_illegal;
      own_d  = gnt;
      last_d = gnt;
    end
  end

  // State register; reset drops any buffered result immediately.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_EMPTY;
      res_q   <= '0;
      err_q   <= 1'b0;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      err_q   <= err_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

  // Response ports show the buffer only to its owner; zero otherwise.
  always_comb begin
    rsp0_valid  = full & (own_q == 1'b0);
    rsp1_valid  = full & (own_q == 1'b1);
    rsp0_result = rsp0_valid ? res_q : 32'd0;
    rsp1_result = rsp1_valid ? res_q : 32'd0;
    rsp0_err    = rsp0_valid & err_q;
    rsp1_err    = rsp1_valid & err_q;
  end

endmodule

// File: tb/tb_p_addsub_arb.sv
// Directed bench for p_addsub_arb: one round-robin instance and one
// fixed-priority instance driven by the same request/response inputs.
module tb_p_addsub_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r1_valid;
  logic [31:0] r0_lhs, r0_rhs, r1_lhs, r1_rhs;
  logic [4:0]  r0_pw, r1_pw;
  logic        r0_sub, r1_sub;
  logic        p0_ready, p1_ready;

  logic        a_rdy0, a_rdy1, a_v0, a_v1, a_e0, a_e1;
  logic [31:0] a_res0, a_res1;
  logic        b_rdy0, b_rdy1, b_v0, b_v1, b_e0, b_e1;
  logic [31:0] b_res0, b_res1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  p_addsub_arb #(.FIXED_PRIO(1'b0)) u_rr (
    .g_clk(clk), .g_resetn(rst_n),
    .req0_valid(r0_valid), .req0_ready(a_rdy0), .req0_lhs(r0_lhs), .req0_rhs(r0_rhs),
    .req0_pw(r0_pw), .req0_sub(r0_sub),
    .req1_valid(r1_valid), .req1_ready(a_rdy1), .req1_lhs(r1_lhs), .req1_rhs(r1_rhs),
    .req1_pw(r1_pw), .req1_sub(r1_sub),
    .rsp0_valid(a_v0), .rsp0_ready(p0_ready), .rsp0_result(a_res0), .rsp0_err(a_e0),
    .rsp1_valid(a_v1), .rsp1_ready(p1_ready), .rsp1_result(a_res1), .rsp1_err(a_e1)
  );

  p_addsub_arb #(.FIXED_PRIO(1'b1)) u_fp (
    .g_clk(clk), .g_resetn(rst_n),
    .req0_valid(r0_valid), .req0_ready(b_rdy0), .req0_lhs(r0_lhs), .req0_rhs(r0_rhs),
    .req0_pw(r0_pw), .req0_sub(r0_sub),
    .req1_valid(r1_valid), .req1_ready(b_rdy1), .req1_lhs(r1_lhs), .req1_rhs(r1_rhs),
    .req1_pw(r1_pw), .req1_sub(r1_sub),
    .rsp0_valid(b_v0), .rsp0_ready(p0_ready), .rsp0_result(b_res0), .rsp0_err(b_e0),
    .rsp1_valid(b_v1), .rsp1_ready(p1_ready), .rsp1_result(b_res1), .rsp1_err(b_e1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_lhs = 32'h01FF0080; r0_rhs = 32'h01010080; r0_pw = 5'b00100; r0_sub = 1'b0;
    r1_lhs = 32'h00010000; r1_rhs = 32'h00020001; r1_pw = 5'b00010; r1_sub = 1'b1;
    p0_ready = 1'b1; p1_ready = 1'b1;

    // Reset with both requests valid: nothing ready, nothing valid.
    cyc(); cyc();
    chk("rst_rdy0", {31'd0, a_rdy0}, 32'd0);
    chk("rst_rdy1", {31'd0, a_rdy1}, 32'd0);
    chk("rst_v0",   {31'd0, a_v0},   32'd0);
    chk("rst_v1",   {31'd0, a_v1},   32'd0);
    chk("rst_res0", a_res0, 32'd0);
    chk("rst_fp_rdy0", {31'd0, b_rdy0}, 32'd0);
    $display("txn reset held: rdy0=%0b rdy1=%0b v0=%0b v1=%0b", a_rdy0, a_rdy1, a_v0, a_v1);
    rst_n = 1'b1;
    #1;

    // First tie after reset goes to requester 0 (pw8 add).
    chk("tie0_rdy0", {31'd0, a_rdy0}, 32'd1);
    chk("tie0_rdy1", {31'd0, a_rdy1}, 32'd0);
    cyc();
    chk("pw8_v0",  {31'd0, a_v0}, 32'd1);
    chk("pw8_res", a_res0, 32'h02000000);
    chk("pw8_err", {31'd0, a_e0}, 32'd0);
    chk("pw8_v1",  {31'd0, a_v1}, 32'd0);
    $display("txn pw8 add: rsp0=%h err=%0b", a_res0, a_e0);

    // Tie now goes to requester 1 (pw16 sub) with same-cycle pop.
    chk("tie1_rdy1", {31'd0, a_rdy1}, 32'd1);
    chk("tie1_rdy0", {31'd0, a_rdy0}, 32'd0);
    cyc();
    chk("pw16_v1",  {31'd0, a_v1}, 32'd1);
    chk("pw16_res", a_res1, 32'hFFFFFFFF);
    chk("pw16_v0",  {31'd0, a_v0}, 32'd0);
    $display("txn pw16 sub: rsp1=%h err=%0b", a_res1, a_e1);

    // pw32 wraparound on requester 0.
    r0_lhs = 32'hFFFFFFFF; r0_rhs = 32'h00000001; r0_pw = 5'b00001; r0_sub = 1'b0;
    #1;
    chk("alt_rdy0", {31'd0, a_rdy0}, 32'd1);
    cyc();
    chk("pw32_v0",  {31'd0, a_v0}, 32'd1);
    chk("pw32_res", a_res0, 32'h00000000);
    $display("txn pw32 add: rsp0=%h err=%0b", a_res0, a_e0);

    // Illegal pack width on requester 1.
    r1_lhs = 32'h12345678; r1_rhs = 32'h11111111; r1_pw = 5'b00110; r1_sub = 1'b0;
    #1;
    chk("alt_rdy1", {31'd0, a_rdy1}, 32'd1);
    cyc();
    chk("ill_v1",  {31'd0, a_v1}, 32'd1);
    chk("ill_res", a_res1, 32'd0);
    chk("ill_err", {31'd0, a_e1}, 32'd1);
    $display("txn illegal pw: rsp1=%h err=%0b", a_res1, a_e1);

    // Requester 0 result that will sit under back-pressure.
    r0_lhs = 32'h12345678; r0_rhs = 32'h11111111; r0_pw = 5'b00001; r0_sub = 1'b0;
    r1_lhs = 32'h00000010; r1_rhs = 32'h00000001; r1_pw = 5'b01000; r1_sub = 1'b1;
    #1;
    chk("alt2_rdy0", {31'd0, a_rdy0}, 32'd1);
    cyc();
    chk("bp_res_first", a_res0, 32'h23456789);
    p0_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy0", {31'd0, a_rdy0}, 32'd0);
      chk("bp_rdy1", {31'd0, a_rdy1}, 32'd0);
      cyc();
      chk("bp_v0",  {31'd0, a_v0}, 32'd1);
      chk("bp_res", a_res0, 32'h23456789);
      $display("txn backpressure %0d: rsp0=%h rdy1=%0b", k, a_res0, a_rdy1);
    end

    // Release: pop of requester 0 and accept of requester 1 in one cycle.
    p0_ready = 1'b1;
    #1;
    chk("rel_rdy1", {31'd0, a_rdy1}, 32'd1);
    cyc();
    chk("rel_v0",  {31'd0, a_v0}, 32'd0);
    chk("pw4_v1",  {31'd0, a_v1}, 32'd1);
    chk("pw4_res", a_res1, 32'h0000001F);
    chk("pw4_err", {31'd0, a_e1}, 32'd0);
    $display("txn pw4 sub after release: rsp1=%h", a_res1);

    // No valids: readies stay low, buffers drain.
    r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    chk("idle_rdy0", {31'd0, a_rdy0}, 32'd0);
    chk("idle_rdy1", {31'd0, a_rdy1}, 32'd0);
    cyc();
    cyc();
    chk("idle_v1",    {31'd0, a_v1}, 32'd0);
    chk("idle_fp_v0", {31'd0, b_v0}, 32'd0);
    chk("idle_fp_v1", {31'd0, b_v1}, 32'd0);
    $display("txn idle drain: v0=%0b v1=%0b", a_v0, a_v1);

    // Fixed priority: requester 0 wins every tie; round-robin alternates.
    r0_lhs = 32'h00000003; r0_rhs = 32'h00000001; r0_pw = 5'b10000; r0_sub = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_rdy0", {31'd0, b_rdy0}, 32'd1);
      chk("fp_rdy1", {31'd0, b_rdy1}, 32'd0);
      cyc();
      chk("fp_v0",  {31'd0, b_v0}, 32'd1);
      chk("fp_res", b_res0, 32'h00000002);
      $display("txn fixed prio %0d: rsp0=%h", k, b_res0);
    end

    // Reset mid-operation discards the buffered result at once.
    chk("mid_full", {31'd0, a_v0 | a_v1}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_v0",   {31'd0, a_v0}, 32'd0);
    chk("mid_v1",   {31'd0, a_v1}, 32'd0);
    chk("mid_res",  a_res0 | a_res1, 32'd0);
    chk("mid_rdy0", {31'd0, a_rdy0}, 32'd0);
    $display("txn mid reset: v0=%0b v1=%0b", a_v0, a_v1);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("post_rdy0", {31'd0, a_rdy0}, 32'd1);
    cyc();
    chk("post_res", a_res0, 32'h00000002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
